// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one memory port; one transaction in flight (IDLE/ISSUE/WAIT/DONE).
// Optional macro MEM_PORT_ARBITER_LOCK_EN lets the owner re-win the port right after DONE for atomic RMW.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [1:0]            lock,
  output logic [1:0]            gnt,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              win;
  logic              locked;

`ifdef MEM_PORT_ARBITER_LOCK_EN
  logic hold_q, hold_d;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    gnt          = 2'b00;
    rsp_valid    = 2'b00;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    locked       = 1'b0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    hold_d       = hold_q;
    locked       = hold_q & req[owner_q];
`endif

    // Both requesting: the one that did not win last time; otherwise whoever asks.
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
    else                   win = ~last_owner_q;
    if (locked)            win = owner_q;

    unique case (state_q)
      IDLE: begin
`ifdef MEM_PORT_ARBITER_LOCK_EN
        hold_d = 1'b0;
`endif
        if (|req) begin
          gnt[win]     = 1'b1;
          owner_d      = win;
          last_owner_d = locked ? last_owner_q : win;
          we_d         = req_we[win];
          addr_d       = win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          wdata_d      = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_q;
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 3'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        rsp_valid[owner_q] = 1'b1;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        hold_d = lock[owner_q] & req[owner_q];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // gnt is combinational from req, so keep it quiet while reset is held.
    gnt = gnt & {2{rst_n}};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= 3'd0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
      hold_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
`ifdef MEM_PORT_ARBITER_LOCK_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_data  = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
